// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side controller. Sequences the PC register, issues one
// instruction fetch at a time over a valid/data_ok handshake, buffers the
// returned word until decode takes it, and handles execute-stage redirects,
// including throwing away responses for fetches that were already in flight.
module pc_sequencer #(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  output logic [63:0] pc_nxt,
  output logic [1:0]  PCWrite,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall_d,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  // PC register control encodings.
  localparam logic [1:0] PCW_LOAD = 2'b00;
  localparam logic [1:0] PCW_HOLD = 2'b01;

  // IDLE: no request. FETCH: request out, result wanted.
  // DISCARD: request out, result unwanted. HOLD: instruction buffered.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_req_addr;
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;

  logic        w_fetch_done;   // a wanted response arrives this cycle
  logic [63:0] w_pc_plus4;

  assign w_pc_plus4   = pc + 64'd4;
  assign w_fetch_done = (r_state == S_FETCH) && iresp_data_ok && !redirect_valid;

  assign ireq_valid = (r_state == S_FETCH) || (r_state == S_DISCARD);
  assign inst_valid = (r_state == S_HOLD);
  assign ireq_addr  = r_req_addr;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

  // Next-PC selection: a redirect always wins, otherwise the PC advances only
  // when a wanted fetch completes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path in combinational logic would infer a latch).
    pc_nxt  = w_pc_plus4;
    PCWrite = PCW_HOLD;
    if (redirect_valid) begin
      pc_nxt  = redirect_pc;
      PCWrite = PCW_LOAD;
    end else if (w_fetch_done) begin
      PCWrite = PCW_LOAD;
    end
  end

  // Fetch state machine with request address and instruction buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req_addr <= PCINIT;
      r_inst     <= 32'd0;
      r_inst_pc  <= 64'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      unique case (r_state)
        S_IDLE: begin
          if (!redirect_valid) begin
            r_req_addr <= pc;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (redirect_valid) begin
            // The response that is (or will be) returned belongs to the old path.
            r_state <= iresp_data_ok ? S_IDLE : S_DISCARD;
          end else if (iresp_data_ok) begin
            r_inst    <= iresp_data;
            r_inst_pc <= r_req_addr;
            r_state   <= S_HOLD;
          end
        end
        S_DISCARD: begin
          // Further redirects only move the PC; the bus still owes a response.
          if (iresp_data_ok) r_state <= S_IDLE;
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_state <= S_IDLE;
          end else if (!stall_d) begin
            r_req_addr <= pc;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
